// File: rtl/alu_pkg.sv
// Shared encodings for the sequential add/subtract block.
package alu_pkg;

   // Controller states of the chunked add/subtract sequencer
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Operation select encodings
   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/add_chunk.sv
// Combinational CHUNK-bit ripple adder with carry-in.
// Also exposes the carry into the slice MSB for signed-overflow detection.
module add_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout,
   output logic             cmsb
);

   logic [CHUNK:0] cv;

   // Ripple the carry from bit 0 upward, one full adder per bit
   always_comb begin
      cv    = '0;
      sum   = '0;
      cv[0] = cin;
      for (int unsigned i = 0; i < CHUNK; i++) begin
         sum[i]  = a[i] ^ b[i] ^ cv[i];
         cv[i+1] = (a[i] & b[i]) | (a[i] & cv[i]) | (b[i] & cv[i]);
      end
      cmsb = cv[CHUNK-1];
      cout = cv[CHUNK];
   end

endmodule

// File: rtl/addsub_seq.sv
// Sequential signed add/subtract: processes CHUNK bits per cycle, LSB slice
// first, with a ready/valid handshake on both the operand and result sides.
module addsub_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int NCHUNK = (CHUNK > 0) ? (WIDTH / CHUNK) : 1;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

   // Reject geometries that cannot be split into whole slices
   generate
      if (CHUNK < 1) begin : g_bad_chunk
         $error("addsub_seq: CHUNK must be at least 1");
      end else if ((WIDTH % CHUNK) != 0) begin : g_bad_width
         $error("addsub_seq: WIDTH must be a multiple of CHUNK");
      end
   endgenerate

   state_t            state;
   logic [WIDTH-1:0]  a_r;
   logic [WIDTH-1:0]  b_r;
   logic              carry;
   logic [IDXW-1:0]   idx;

   int unsigned       off;
   logic [CHUNK-1:0]  a_sl;
   logic [CHUNK-1:0]  b_sl;
   logic [CHUNK-1:0]  sum_sl;
   logic              c_out;
   logic              c_msb;
   logic [WIDTH-1:0]  s_next;

   // Select the operand slices addressed by the chunk index
   always_comb begin
      off  = 32'(idx) * CHUNK;
      a_sl = a_r[off +: CHUNK];
      b_sl = b_r[off +: CHUNK];
   end

   add_chunk #(
      .CHUNK (CHUNK)
   ) u_add_chunk (
      .a    (a_sl),
      .b    (b_sl),
      .cin  (carry),
      .sum  (sum_sl),
      .cout (c_out),
      .cmsb (c_msb)
   );

   // Result with the current slice merged in; lets zero be decided on the last edge
   always_comb begin
      s_next             = s;
      s_next[off +: CHUNK] = sum_sl;
   end

   // Handshake controller and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         s         <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
         zero      <= 1'b0;
         carry     <= 1'b0;
         idx       <= '0;
         a_r       <= '0;
         b_r       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  // Subtraction is A + ~B + 1: invert B here, seed carry with op
                  a_r      <= a;
                  b_r      <= (op == OP_SUB) ? ~b : b;
                  carry    <= op;
                  idx      <= '0;
                  in_ready <= 1'b0;
                  state    <= CALC;
               end
            end
            CALC: begin
               s     <= s_next;
               carry <= c_out;
               if (idx == LAST) begin
                  cout      <= c_out;
                  ovf       <= c_msb ^ c_out;
                  zero      <= (s_next == '0);
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_addsub_seq.sv
// Directed self-checking bench for addsub_seq (WIDTH=8, CHUNK=4 plus a CHUNK=8 instance).
module tb_addsub_seq;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic       op;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] s;
   logic       cout;
   logic       ovf;
   logic       zero;

   logic       in_valid2;
   logic       in_ready2;
   logic       out_valid2;
   logic       out_ready2;
   logic [7:0] s2;
   logic       cout2;
   logic       ovf2;
   logic       zero2;

   int nchk;
   int nfail;

   addsub_seq #(.WIDTH(8), .CHUNK(4)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .cout      (cout),
      .ovf       (ovf),
      .zero      (zero)
   );

   addsub_seq #(.WIDTH(8), .CHUNK(8)) u_dut_full (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid2),
      .in_ready  (in_ready2),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid2),
      .out_ready (out_ready2),
      .s         (s2),
      .cout      (cout2),
      .ovf       (ovf2),
      .zero      (zero2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue one operation on the CHUNK=4 instance, scramble inputs after
   // acceptance, wait (bounded) for out_valid, capture, then release it.
   task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic iop,
                        output logic [7:0] rs, output logic rc, output logic ro,
                        output logic rz, output int cyc);
      @(negedge clk);
      a = ia; b = ib; op = iop; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = ~ia; b = ia ^ 8'h5A; op = ~iop;
      cyc = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         cyc++;
         if (out_valid) break;
      end
      if (!out_valid) cyc = -1;
      rs = s; rc = cout; ro = ovf; rz = zero;
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_valid2 = 1'b0; out_ready2 = 1'b0;
      a = '0; b = '0; op = 1'b0;
      #12;
      nchk++; if (in_ready !== 1'b1) begin nfail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      nchk++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      nchk++; if ({s, cout, ovf, zero} !== 11'd0) begin nfail++; $display("FAIL reset_outputs got s=%h c=%b o=%b z=%b exp all 0", s, cout, ovf, zero); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_arith();
      logic [7:0] va[5];
      logic [7:0] vb[5];
      logic       vop[5];
      logic [7:0] es[5];
      logic       ec[5];
      logic       eo[5];
      logic       ez[5];
      logic [7:0] rs;
      logic       rc, ro, rz;
      int         cyc;
      va[0] = 8'd100; vb[0] = 8'd27; vop[0] = 1'b0; es[0] = 8'h7F; ec[0] = 0; eo[0] = 0; ez[0] = 0;
      va[1] = 8'd127; vb[1] = 8'd1;  vop[1] = 1'b0; es[1] = 8'h80; ec[1] = 0; eo[1] = 1; ez[1] = 0;
      va[2] = 8'h80;  vb[2] = 8'd1;  vop[2] = 1'b1; es[2] = 8'h7F; ec[2] = 1; eo[2] = 1; ez[2] = 0;
      va[3] = 8'd3;   vb[3] = 8'd5;  vop[3] = 1'b1; es[3] = 8'hFE; ec[3] = 0; eo[3] = 0; ez[3] = 0;
      va[4] = 8'd5;   vb[4] = 8'd5;  vop[4] = 1'b1; es[4] = 8'h00; ec[4] = 1; eo[4] = 0; ez[4] = 1;
      for (int i = 0; i < 5; i++) begin
         do_op(va[i], vb[i], vop[i], rs, rc, ro, rz, cyc);
         nchk++; if (cyc !== 2) begin nfail++; $display("FAIL arith%0d_latency got=%0d exp=2", i, cyc); end
         nchk++; if ({rs, rc, ro, rz} !== {es[i], ec[i], eo[i], ez[i]})
            begin nfail++; $display("FAIL arith%0d_result got s=%h c=%b o=%b z=%b exp s=%h c=%b o=%b z=%b",
                                    i, rs, rc, ro, rz, es[i], ec[i], eo[i], ez[i]); end
      end
   endtask

   task automatic test_hold();
      int cyc;
      @(negedge clk);
      a = 8'h10; b = 8'h20; op = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      cyc = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         cyc++;
         if (out_valid) break;
      end
      nchk++; if (out_valid !== 1'b1) begin nfail++; $display("FAIL hold_done_reached got=%b exp=1 after %0d", out_valid, cyc); end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         in_valid = 1'b1; a = 8'(k * 37 + 3); b = 8'(k * 11 + 9); op = k[0];
         @(posedge clk); #1;
         nchk++; if ({s, cout, ovf, zero, in_ready, out_valid} !== {8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1})
            begin nfail++; $display("FAIL hold_cycle%0d got s=%h c=%b o=%b z=%b ir=%b ov=%b exp s=30 c=0 o=0 z=0 ir=0 ov=1",
                                    k, s, cout, ovf, zero, in_ready, out_valid); end
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      nchk++; if ({in_ready, out_valid} !== 2'b10) begin nfail++; $display("FAIL hold_release got ir=%b ov=%b exp ir=1 ov=0", in_ready, out_valid); end
   endtask

   task automatic test_reset_mid();
      int cyc;
      @(negedge clk);
      a = 8'h55; b = 8'h22; op = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      nchk++; if (s[3:0] !== 4'h7) begin nfail++; $display("FAIL midcalc_low_slice got=%h exp=7", s[3:0]); end
      #2 rst_n = 1'b0;
      #1;
      nchk++; if ({out_valid, s, in_ready} !== {1'b0, 8'h00, 1'b1})
         begin nfail++; $display("FAIL async_reset got ov=%b s=%h ir=%b exp ov=0 s=00 ir=1", out_valid, s, in_ready); end
      @(negedge clk);
      rst_n = 1'b1; a = 8'd20; b = 8'd22; op = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      nchk++; if (in_ready !== 1'b0) begin nfail++; $display("FAIL first_accept got ir=%b exp=0", in_ready); end
      cyc = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         cyc++;
         if (out_valid) break;
      end
      nchk++; if ({cyc, s, cout, ovf, zero} !== {32'd2, 8'd42, 1'b0, 1'b0, 1'b0})
         begin nfail++; $display("FAIL post_reset_op got cyc=%0d s=%0d c=%b o=%b z=%b exp cyc=2 s=42 c=0 o=0 z=0", cyc, s, cout, ovf, zero); end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [7:0] va[4];
      logic [7:0] vb[4];
      logic       vop[4];
      logic [10:0] exp_r[4];
      int idx_in, got, last;
      va[0] = 8'd1;   vb[0] = 8'd2;   vop[0] = 1'b0; exp_r[0] = {8'h03, 1'b0, 1'b0, 1'b0};
      va[1] = 8'd10;  vb[1] = 8'd3;   vop[1] = 1'b1; exp_r[1] = {8'h07, 1'b1, 1'b0, 1'b0};
      va[2] = 8'h7F;  vb[2] = 8'h7F;  vop[2] = 1'b0; exp_r[2] = {8'hFE, 1'b0, 1'b1, 1'b0};
      va[3] = 8'd0;   vb[3] = 8'd0;   vop[3] = 1'b1; exp_r[3] = {8'h00, 1'b1, 1'b0, 1'b1};
      idx_in = 0; got = 0; last = 0;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
         @(negedge clk);
         if (in_ready) begin
            if (idx_in < 4) begin
               a = va[idx_in]; b = vb[idx_in]; op = vop[idx_in]; in_valid = 1'b1;
               idx_in++;
            end else begin
               in_valid = 1'b0;
            end
         end
         @(posedge clk); #1;
         if (out_valid) begin
            nchk++; if ({s, cout, ovf, zero} !== exp_r[got])
               begin nfail++; $display("FAIL b2b%0d_result got=%h exp=%h", got, {s, cout, ovf, zero}, exp_r[got]); end
            if (got > 0) begin
               nchk++; if (cyc - last !== 4) begin nfail++; $display("FAIL b2b%0d_spacing got=%0d exp=4", got, cyc - last); end
            end
            last = cyc;
            got++;
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      nchk++; if (got !== 4) begin nfail++; $display("FAIL b2b_count got=%0d exp=4", got); end
      @(posedge clk); #1;
   endtask

   task automatic test_chunk_full();
      int cyc;
      @(negedge clk);
      a = 8'd100; b = 8'd27; op = 1'b0; in_valid2 = 1'b1; out_ready2 = 1'b0;
      @(posedge clk); #1;
      in_valid2 = 1'b0;
      cyc = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         cyc++;
         if (out_valid2) break;
      end
      nchk++; if ({cyc, s2, cout2, ovf2, zero2} !== {32'd1, 8'h7F, 1'b0, 1'b0, 1'b0})
         begin nfail++; $display("FAIL full_chunk got cyc=%0d s=%h c=%b o=%b z=%b exp cyc=1 s=7f c=0 o=0 z=0", cyc, s2, cout2, ovf2, zero2); end
      @(negedge clk);
      out_ready2 = 1'b1;
      @(posedge clk); #1;
      out_ready2 = 1'b0;
   endtask

   initial begin
      nchk = 0;
      nfail = 0;
      test_reset();
      test_arith();
      test_hold();
      test_reset_mid();
      test_back_to_back();
      test_chunk_full();
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
